// File: rtl/issue_sched_if.sv
// Decoder-to-scheduler op bus: one decoded op per valid/ready handshake.
interface issue_sched_if;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic [2:0] op_d;
    logic       op_dw;
    logic       op_fw;
    logic       op_fr;

    modport master (
        output op_valid, op_a, op_b, op_d, op_dw, op_fw, op_fr,
        input  op_ready
    );

    modport slave (
        input  op_valid, op_a, op_b, op_d, op_dw, op_fw, op_fr,
        output op_ready
    );
endinterface

// File: rtl/issue_sched.sv
// Single-issue scheduler: regfile read addressing, one-op execute slot, writeback strobes,
// RMW flag-write arbitration and ALU watchdog. Build option ISSUE_BYPASS_EN removes the RAW bubble.
module issue_sched #(
    parameter int PC_REG     = 3,
    parameter int TMO_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    issue_sched_if.slave dec,
    output logic [2:0]  r_a_addr,
    output logic [2:0]  r_b_addr,
    output logic        alu_start,
    input  logic        alu_done,
    output logic        alu_d_wr,
    output logic [2:0]  alu_d_adr,
    output logic        alu_sf_wr,
    input  logic        rmw_req,
    output logic        rmw_sf_w,
    input  logic        flush,
    output logic        x_busy,
    output logic        exec_tmo
);

    localparam int             WD_W    = $clog2(TMO_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYCLES - 1);

    typedef enum logic {X_IDLE, X_BUSY} x_state_e;

    x_state_e        x_state_q, x_state_d;
    logic [2:0]      x_dst_q, x_dst_d;
    logic            x_dw_q, x_dw_d;
    logic            x_fw_q, x_fw_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            tmo_q, tmo_d;
    logic            start_q, start_d;

    logic       x_done;
    logic       expire;
    logic       hazard;
    logic       fire;
    logic       writeback;
    logic [1:0] src_hit;
    logic [2:0] src_idx [2];

    assign r_a_addr   = dec.op_a;
    assign r_b_addr   = dec.op_b;
    assign src_idx[0] = dec.op_a;
    assign src_idx[1] = dec.op_b;

    assign x_busy = (x_state_q == X_BUSY);
    assign x_done = x_busy & alu_done;
    assign expire = x_busy & ~alu_done & (wdog_q == WD_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = (src_idx[gi] == x_dst_q);
        end
    endgenerate

`ifdef ISSUE_BYPASS_EN
    // Regfile forwards the same-cycle write to the read port, so dependents issue immediately.
    assign hazard = 1'b0;
`else
    localparam logic [2:0] PC_IDX = 3'(PC_REG);
    assign hazard = x_done & x_dw_q & (x_dst_q != PC_IDX) & (|src_hit);
`endif

    // A waiting flag reader yields to the memory unit's RMW flag update.
    assign dec.op_ready = ~rst & ~flush & (~x_busy | x_done) & ~hazard
                        & ~(dec.op_fr & rmw_req);
    assign fire         = dec.op_valid & dec.op_ready;

    assign writeback = x_done & ~flush & ~rst;
    assign alu_d_wr  = writeback & x_dw_q;
    assign alu_sf_wr = writeback & x_fw_q;
    assign alu_d_adr = x_busy ? x_dst_q : 3'd0;
    assign alu_start = start_q & ~rst;
    assign exec_tmo  = tmo_q;

    // The RMW is younger than a flag-writing op in execute, so it waits for that op to retire.
    assign rmw_sf_w = rmw_req & ~(x_busy & x_fw_q) & ~rst;

    always_comb begin
        x_state_d = x_state_q;
        x_dst_d   = x_dst_q;
        x_dw_d    = x_dw_q;
        x_fw_d    = x_fw_q;
        wdog_d    = wdog_q;
        tmo_d     = tmo_q;
        start_d   = fire;

        if (fire) begin
            x_state_d = X_BUSY;
            x_dst_d   = dec.op_d;
            x_dw_d    = dec.op_dw;
            x_fw_d    = dec.op_fw;
            wdog_d    = '0;
        end else if (x_busy) begin
            if (flush || alu_done || expire) begin
                x_state_d = X_IDLE;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end

        // A flushed op is killed, not timed out.
        if (expire && !flush) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_state_q <= X_IDLE;
            x_dst_q   <= 3'd0;
            x_dw_q    <= 1'b0;
            x_fw_q    <= 1'b0;
            wdog_q    <= '0;
            tmo_q     <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            x_state_q <= x_state_d;
            x_dst_q   <= x_dst_d;
            x_dw_q    <= x_dw_d;
            x_fw_q    <= x_fw_d;
            wdog_q    <= wdog_d;
            tmo_q     <= tmo_d;
            start_q   <= start_d;
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched: idle-state vector table plus multi-cycle sequences.
module tb_issue_sched;

`ifdef ISSUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] r_a_addr, r_b_addr, alu_d_adr;
    logic       alu_start, alu_done, alu_d_wr, alu_sf_wr;
    logic       rmw_req, rmw_sf_w, flush, x_busy, exec_tmo;

    always #5 clk = ~clk;

    issue_sched_if dec_if ();

    issue_sched #(.PC_REG(3), .TMO_CYCLES(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .dec       (dec_if),
        .r_a_addr  (r_a_addr),
        .r_b_addr  (r_b_addr),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .alu_d_wr  (alu_d_wr),
        .alu_d_adr (alu_d_adr),
        .alu_sf_wr (alu_sf_wr),
        .rmw_req   (rmw_req),
        .rmw_sf_w  (rmw_sf_w),
        .flush     (flush),
        .x_busy    (x_busy),
        .exec_tmo  (exec_tmo)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       fr;
        logic       rmw;
        logic       fl;
        logic       done;
        logic       exp_ready;
        logic       exp_grant;
        logic       exp_dwr;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [2:0] a, input logic [2:0] b,
                            input logic [2:0] d, input logic dw, input logic fw, input logic fr);
        dec_if.op_valid = v;
        dec_if.op_a     = a;
        dec_if.op_b     = b;
        dec_if.op_d     = d;
        dec_if.op_dw    = dw;
        dec_if.op_fw    = fw;
        dec_if.op_fr    = fr;
    endtask

    initial begin
        logic wr_seen;

        vecs[0] = '{a:3'd1, b:3'd2, fr:0, rmw:0, fl:0, done:0, exp_ready:1, exp_grant:0, exp_dwr:0};
        vecs[1] = '{a:3'd7, b:3'd0, fr:1, rmw:0, fl:0, done:0, exp_ready:1, exp_grant:0, exp_dwr:0};
        vecs[2] = '{a:3'd3, b:3'd4, fr:1, rmw:1, fl:0, done:0, exp_ready:0, exp_grant:1, exp_dwr:0};
        vecs[3] = '{a:3'd5, b:3'd6, fr:0, rmw:1, fl:0, done:0, exp_ready:1, exp_grant:1, exp_dwr:0};
        vecs[4] = '{a:3'd2, b:3'd2, fr:0, rmw:0, fl:1, done:0, exp_ready:0, exp_grant:0, exp_dwr:0};
        vecs[5] = '{a:3'd0, b:3'd7, fr:1, rmw:1, fl:1, done:0, exp_ready:0, exp_grant:1, exp_dwr:0};
        vecs[6] = '{a:3'd6, b:3'd1, fr:0, rmw:0, fl:0, done:1, exp_ready:1, exp_grant:0, exp_dwr:0};

        rst = 1'b1; alu_done = 1'b0; rmw_req = 1'b0; flush = 1'b0;
        drive_op(1, 3'd1, 3'd2, 3'd4, 1, 0, 0);

        // Reset held two cycles with a valid op waiting
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            chk("rst_ready", dec_if.op_ready, 0);
            chk("rst_busy", x_busy, 0);
            chk("rst_start", alu_start, 0);
        end
        tick(); rst = 1'b0; settle();
        chk("first_issue_ready", dec_if.op_ready, 1);
        chk("raddr_a", r_a_addr, 1);
        chk("raddr_b", r_b_addr, 2);

        // Simple op: start at T+1, done at T+3
        tick(); dec_if.op_valid = 1'b0; settle();
        chk("simple_start", alu_start, 1);
        chk("simple_busy", x_busy, 1);
        chk("simple_no_early_wr", alu_d_wr, 0);
        tick(); settle();
        chk("simple_start_pulse", alu_start, 0);
        chk("simple_adr_busy", alu_d_adr, 4);
        tick(); alu_done = 1'b1; settle();
        chk("simple_dwr", alu_d_wr, 1);
        chk("simple_dadr", alu_d_adr, 4);
        chk("simple_sfwr", alu_sf_wr, 0);
        tick(); alu_done = 1'b0; settle();
        chk("simple_idle", x_busy, 0);
        chk("simple_dwr_off", alu_d_wr, 0);
        chk("simple_adr_idle", alu_d_adr, 0);

        // Idle-state vector table (op_valid low so no issue happens)
        for (int i = 0; i < 7; i++) begin
            tick();
            dec_if.op_a = vecs[i].a; dec_if.op_b = vecs[i].b; dec_if.op_fr = vecs[i].fr;
            rmw_req = vecs[i].rmw; flush = vecs[i].fl; alu_done = vecs[i].done;
            settle();
            chk($sformatf("vec%0d_ready", i), dec_if.op_ready, vecs[i].exp_ready);
            chk($sformatf("vec%0d_ra", i), r_a_addr, vecs[i].a);
            chk($sformatf("vec%0d_rb", i), r_b_addr, vecs[i].b);
            chk($sformatf("vec%0d_grant", i), rmw_sf_w, vecs[i].exp_grant);
            chk($sformatf("vec%0d_dwr", i), alu_d_wr, vecs[i].exp_dwr);
        end
        tick(); rmw_req = 1'b0; flush = 1'b0; alu_done = 1'b0; drive_op(0, 0, 0, 0, 0, 0, 0);

        // RAW hazard on d=5
        tick(); drive_op(1, 3'd0, 3'd0, 3'd5, 1, 0, 0); settle();
        chk("raw_op1_ready", dec_if.op_ready, 1);
        tick(); drive_op(1, 3'd5, 3'd1, 3'd0, 0, 0, 0); settle();
        chk("raw_op1_start", alu_start, 1);
        chk("raw_busy_ready", dec_if.op_ready, 0);
        tick(); alu_done = 1'b1; settle();
        chk("raw_done_ready", dec_if.op_ready, BYP);
        chk("raw_op1_dwr", alu_d_wr, 1);
        tick(); alu_done = 1'b0; settle();
        chk("raw_next_ready", dec_if.op_ready, !BYP);
        chk("raw_next_start", alu_start, BYP);
        tick(); dec_if.op_valid = 1'b0; settle();
        chk("raw_late_start", alu_start, !BYP);
        chk("raw_op2_busy", x_busy, 1);
        tick(); alu_done = 1'b1;
        tick(); alu_done = 1'b0; settle();
        chk("raw_retired", x_busy, 0);

        // Source equal to PC_REG never stalls
        tick(); drive_op(1, 3'd0, 3'd0, 3'd3, 1, 0, 0); settle();
        chk("pc_op1_ready", dec_if.op_ready, 1);
        tick(); drive_op(1, 3'd3, 3'd3, 3'd1, 0, 0, 0); settle();
        chk("pc_busy_ready", dec_if.op_ready, 0);
        tick(); alu_done = 1'b1; settle();
        chk("pc_done_ready", dec_if.op_ready, 1);
        tick(); alu_done = 1'b0; dec_if.op_valid = 1'b0; settle();
        chk("pc_op2_start", alu_start, 1);
        tick(); alu_done = 1'b1;
        tick(); alu_done = 1'b0;

        // RMW waits for the flag writer; flag reader waits for the grant
        tick(); drive_op(1, 3'd1, 3'd1, 3'd1, 0, 1, 0); settle();
        chk("rmw_fw_ready", dec_if.op_ready, 1);
        tick(); rmw_req = 1'b1; drive_op(1, 3'd2, 3'd2, 3'd2, 1, 0, 1); settle();
        chk("rmw_grant_start", rmw_sf_w, 0);
        chk("rmw_fr_ready_start", dec_if.op_ready, 0);
        tick(); settle();
        chk("rmw_grant_busy", rmw_sf_w, 0);
        tick(); alu_done = 1'b1; settle();
        chk("rmw_sfwr", alu_sf_wr, 1);
        chk("rmw_grant_done", rmw_sf_w, 0);
        chk("rmw_fr_ready_done", dec_if.op_ready, 0);
        tick(); alu_done = 1'b0; settle();
        chk("rmw_grant_after", rmw_sf_w, 1);
        chk("rmw_idle", x_busy, 0);
        chk("rmw_fr_ready_grant", dec_if.op_ready, 0);
        tick(); rmw_req = 1'b0; settle();
        chk("rmw_fr_ready_released", dec_if.op_ready, 1);
        chk("rmw_grant_off", rmw_sf_w, 0);
        tick(); dec_if.op_valid = 1'b0; settle();
        chk("rmw_fr_start", alu_start, 1);
        tick(); alu_done = 1'b1;
        tick(); alu_done = 1'b0;

        // Flush kills the op in execute
        tick(); drive_op(1, 3'd1, 3'd2, 3'd6, 1, 1, 0); settle();
        chk("flush_issue_ready", dec_if.op_ready, 1);
        tick(); dec_if.op_valid = 1'b0; settle();
        tick(); flush = 1'b1; alu_done = 1'b1; dec_if.op_valid = 1'b1; settle();
        chk("flush_dwr", alu_d_wr, 0);
        chk("flush_sfwr", alu_sf_wr, 0);
        chk("flush_ready", dec_if.op_ready, 0);
        tick(); flush = 1'b0; alu_done = 1'b0; dec_if.op_valid = 1'b0; settle();
        chk("flush_idle", x_busy, 0);
        chk("flush_no_start", alu_start, 0);

        // Watchdog: no done for 64 busy cycles
        tick(); drive_op(1, 3'd0, 3'd0, 3'd2, 1, 0, 0); settle();
        chk("wd_issue_ready", dec_if.op_ready, 1);
        tick(); dec_if.op_valid = 1'b0; settle();
        chk("wd_start", alu_start, 1);
        wr_seen = 1'b0;
        for (int i = 1; i < 64; i++) begin
            tick(); settle();
            if (alu_d_wr) wr_seen = 1'b1;
        end
        chk("wd_busy_last", x_busy, 1);
        chk("wd_tmo_not_yet", exec_tmo, 0);
        chk("wd_no_dwr", wr_seen, 0);
        tick(); settle();
        chk("wd_aborted", x_busy, 0);
        chk("wd_tmo_set", exec_tmo, 1);

        // Later issue proceeds normally, exec_tmo stays sticky
        tick(); drive_op(1, 3'd0, 3'd0, 3'd7, 1, 0, 0); settle();
        chk("wd_reissue_ready", dec_if.op_ready, 1);
        tick(); dec_if.op_valid = 1'b0; settle();
        chk("wd_reissue_start", alu_start, 1);
        tick(); alu_done = 1'b1; settle();
        chk("wd_reissue_dwr", alu_d_wr, 1);
        chk("wd_reissue_adr", alu_d_adr, 7);
        chk("wd_tmo_sticky", exec_tmo, 1);

        // Done on the expiry cycle wins
        tick(); alu_done = 1'b0; drive_op(1, 3'd0, 3'd0, 3'd1, 1, 0, 0); settle();
        chk("wd_exp_issue_ready", dec_if.op_ready, 1);
        tick(); dec_if.op_valid = 1'b0; settle();
        for (int i = 1; i < 63; i++) tick();
        tick(); alu_done = 1'b1; settle();
        chk("wd_exp_dwr", alu_d_wr, 1);
        chk("wd_exp_adr", alu_d_adr, 1);
        tick(); alu_done = 1'b0; settle();
        chk("wd_exp_idle", x_busy, 0);

        // Reset mid-op drops the op and clears exec_tmo
        tick(); drive_op(1, 3'd0, 3'd0, 3'd4, 1, 1, 0); settle();
        chk("rstop_ready", dec_if.op_ready, 1);
        tick(); dec_if.op_valid = 1'b0; settle();
        tick(); rst = 1'b1; alu_done = 1'b1; rmw_req = 1'b1; settle();
        chk("rstop_dwr", alu_d_wr, 0);
        chk("rstop_sfwr", alu_sf_wr, 0);
        chk("rstop_grant", rmw_sf_w, 0);
        chk("rstop_ready_low", dec_if.op_ready, 0);
        tick(); rst = 1'b0; alu_done = 1'b0; rmw_req = 1'b0; settle();
        chk("rstop_idle", x_busy, 0);
        chk("rstop_tmo_clr", exec_tmo, 0);
        chk("rstop_no_start", alu_start, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
